// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: byte width and the
// launcher FSM encoding.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      S_SYNC      = 2'd0,
      S_IDLE      = 2'd1,
      S_WAIT_ACT  = 2'd2,
      S_WAIT_DONE = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with a count register, full/empty flags and a
// sticky overflow flag for writes dropped while full.
module uart_sync_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                      i_Clock,
   input  logic                      i_Rst_L,
   input  logic                      i_Push,
   input  logic [DATA_W-1:0]         i_Push_Data,
   input  logic                      i_Pop,
   output logic [DATA_W-1:0]         o_Pop_Data,
   output logic                      o_Full,
   output logic                      o_Empty,
   output logic [$clog2(DEPTH):0]    o_Count,
   input  logic                      i_Ovf_Clr,
   output logic                      o_Overflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              push_ok;
   logic              pop_ok;
   logic              drop;

   // Full/empty come from the count alone; pointers only address storage.
   assign o_Full     = (count == FULL_CNT);
   assign o_Empty    = (count == '0);
   assign o_Count    = count;
   assign o_Pop_Data = mem[rd_ptr];

   // Acceptance uses the pre-edge count, so a pop never frees room for a
   // write in the same cycle.
   assign push_ok = i_Push && !o_Full;
   assign pop_ok  = i_Pop && !o_Empty;
   assign drop    = i_Push && o_Full;

   always_ff @(posedge i_Clock) begin
      if (push_ok) mem[wr_ptr] <= i_Push_Data;
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_Overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)           o_Overflow <= 1'b1;
         else if (i_Ovf_Clr) o_Overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes from system logic and launches them into the UART transmitter
// one frame at a time, waiting for each frame to finish before the next.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                      i_Clock,
   input  logic                      i_Rst_L,
   input  logic                      i_Wr_DV,
   input  logic [UART_DATA_W-1:0]    i_Wr_Byte,
   output logic                      o_Full,
   output logic                      o_Empty,
   output logic [$clog2(DEPTH):0]    o_Count,
   output logic                      o_Overflow,
   input  logic                      i_Ovf_Clr,
   output logic                      o_Tx_DV,
   output logic [UART_DATA_W-1:0]    o_Tx_Byte,
   input  logic                      i_Tx_Active,
   input  logic                      i_Tx_Done,
   output logic                      o_Busy
);

   feeder_state_t            state;
   feeder_state_t            state_nx;
   logic                     launch;
   logic [UART_DATA_W-1:0]   fifo_data;

   uart_sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (UART_DATA_W)
   ) u_fifo (
      .i_Clock     (i_Clock),
      .i_Rst_L     (i_Rst_L),
      .i_Push      (i_Wr_DV),
      .i_Push_Data (i_Wr_Byte),
      .i_Pop       (launch),
      .o_Pop_Data  (fifo_data),
      .o_Full      (o_Full),
      .o_Empty     (o_Empty),
      .o_Count     (o_Count),
      .i_Ovf_Clr   (i_Ovf_Clr),
      .o_Overflow  (o_Overflow)
   );

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state     <= S_SYNC;
         o_Tx_DV   <= 1'b0;
         o_Tx_Byte <= '0;
      end else begin
         state   <= state_nx;
         o_Tx_DV <= launch;
         if (launch) o_Tx_Byte <= fifo_data;
      end
   end

   // S_SYNC covers a transmitter that was not reset with us and may still be
   // mid-frame; S_WAIT_ACT keeps the trailing Done cycle of the previous
   // frame from being mistaken for completion of the new one.
   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      case (state)
         S_SYNC:      if (!i_Tx_Active && !i_Tx_Done) state_nx = S_IDLE;
         S_IDLE: begin
            if (!o_Empty) begin
               launch   = 1'b1;
               state_nx = S_WAIT_ACT;
            end
         end
         S_WAIT_ACT:  if (i_Tx_Active) state_nx = S_WAIT_DONE;
         S_WAIT_DONE: if (i_Tx_Done)   state_nx = S_IDLE;
         default:     state_nx = S_SYNC;
      endcase
   end

   assign o_Busy = (state != S_IDLE) || !o_Empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: drives a behavioural UART transmitter
// (CLKS_PER_BIT = 4), decodes the serial line, and compares every cycle
// against a queue-based model of the feeder.
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;
   localparam int CPB   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       wr;
   logic       clr;
   logic [7:0] wbyte;
   logic       full, empty, ovf, dv, busy;
   logic [4:0] cnt;
   logic [7:0] txb;

   // transmitter model (no reset, like the real one)
   logic       tx_act  = 1'b0;
   logic       tx_done = 1'b0;
   logic       tx_ser  = 1'b1;
   int         tx_st   = 0;
   int         tx_cnt  = 0;
   int         tx_bit  = 0;
   logic [7:0] tx_data = 8'h00;

   uart_tx_feeder #(.DEPTH(DEPTH)) dut (
      .i_Clock     (clk),
      .i_Rst_L     (rst_n),
      .i_Wr_DV     (wr),
      .i_Wr_Byte   (wbyte),
      .o_Full      (full),
      .o_Empty     (empty),
      .o_Count     (cnt),
      .o_Overflow  (ovf),
      .i_Ovf_Clr   (clr),
      .o_Tx_DV     (dv),
      .o_Tx_Byte   (txb),
      .i_Tx_Active (tx_act),
      .i_Tx_Done   (tx_done),
      .o_Busy      (busy)
   );

   always @(posedge clk) begin
      case (tx_st)
         0: begin
            tx_ser <= 1'b1; tx_done <= 1'b0; tx_cnt <= 0; tx_bit <= 0;
            if (dv) begin tx_act <= 1'b1; tx_data <= txb; tx_st <= 1; end
         end
         1: begin
            tx_ser <= 1'b0;
            if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
            else begin tx_cnt <= 0; tx_st <= 2; end
         end
         2: begin
            tx_ser <= tx_data[tx_bit];
            if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
            else begin
               tx_cnt <= 0;
               if (tx_bit < 7) tx_bit <= tx_bit + 1;
               else begin tx_bit <= 0; tx_st <= 3; end
            end
         end
         3: begin
            tx_ser <= 1'b1;
            if (tx_cnt < CPB-1) tx_cnt <= tx_cnt + 1;
            else begin tx_cnt <= 0; tx_done <= 1'b1; tx_act <= 1'b0; tx_st <= 4; end
         end
         default: begin tx_done <= 1'b1; tx_st <= 0; end
      endcase
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // reference model: byte queue plus frame lifecycle
   logic [7:0] mq[$];
   logic [7:0] rx_exp[$];
   bit         m_sync, m_pend, m_start, m_ovf, m_dv;
   logic [7:0] m_byte;
   int         cyc = 0;
   int         n_dv = 0;
   int         peak = 0;
   int         rise_cyc = -1;
   int         gap_from = 0;
   bit         gap_on = 0;
   logic       prev_done = 1'b0;

   task automatic model_reset();
      // a launch pulse killed by reset never reaches the transmitter
      if (m_dv && rx_exp.size() != 0) void'(rx_exp.pop_back());
      mq.delete();
      m_sync = 0; m_pend = 0; m_start = 0; m_ovf = 0; m_dv = 0; m_byte = 8'h00;
   endtask

   task automatic model_edge();
      int sz;
      bit pop, push_ok, drop;
      if (!rst_n) begin model_reset(); return; end
      sz      = mq.size();
      pop     = m_sync && !m_pend && sz > 0;
      push_ok = wr && sz < DEPTH;
      drop    = wr && sz == DEPTH;
      m_dv    = pop;
      if (pop) begin m_byte = mq.pop_front(); rx_exp.push_back(m_byte); end
      if (push_ok) mq.push_back(wbyte);
      if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
      if (!m_sync) m_sync = !tx_act && !tx_done;
      else if (pop) begin m_pend = 1; m_start = 0; end
      else if (m_pend && !m_start) m_start = tx_act;
      else if (m_pend && m_start && tx_done) m_pend = 0;
   endtask

   task automatic check_all();
      chk("count", cnt, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("overflow", ovf, m_ovf);
      chk("tx_dv", dv, m_dv);
      chk("tx_byte", txb, m_byte);
      chk("busy", busy, !m_sync || m_pend || mq.size() != 0);
      chk("dv_vs_active", dv & tx_act, 0);
      chk("dv_vs_done", dv & tx_done, 0);
      if (int'(cnt) > peak) peak = int'(cnt);
      if (tx_done && !prev_done) rise_cyc = cyc;
      prev_done = tx_done;
      if (dv) begin
         n_dv++;
         if (gap_on && rise_cyc > gap_from) chk("gap_after_done", cyc - rise_cyc, 2);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      check_all();
   endtask

   task automatic wait_idle(input string tag, input int limit);
      bit ok = 0;
      for (int i = 0; i < limit; i++) begin
         if (!busy && !tx_act && !tx_done) begin ok = 1; break; end
         tick();
      end
      chk({tag, "_idle"}, ok, 1);
   endtask

   task automatic write_seq(input int n);
      for (int i = 0; i < n; i++) begin
         wr = 1'b1; wbyte = 8'($urandom); tick();
      end
      wr = 1'b0;
   endtask

   // serial decoder: samples mid-bit, LSB first
   initial begin : rx
      logic [7:0] d;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (tx_ser === 1'b0) begin
            repeat (2) @(negedge clk);
            chk("rx_start", tx_ser, 0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               d[i] = tx_ser;
            end
            repeat (CPB) @(negedge clk);
            chk("rx_stop", tx_ser, 1);
            chk("rx_pending", rx_exp.size() != 0, 1);
            if (rx_exp.size() != 0) begin
               e = rx_exp.pop_front();
               chk("rx_byte", d, e);
            end
         end
      end
   end

   initial begin : main
      int  base;
      bit  found;
      rst_n = 1'b0; wr = 1'b0; clr = 1'b0; wbyte = 8'h00;
      model_reset();
      repeat (3) tick();
      chk("rst_busy", busy, 1);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_dv", dv, 0);
      rst_n = 1'b1;
      tick(); tick();

      // single byte: launch two edges after the write
      wr = 1'b1; wbyte = 8'hA5; tick(); wr = 1'b0;
      chk("a5_count", cnt, 1);
      tick();
      chk("a5_dv", dv, 1);
      chk("a5_byte", txb, 8'hA5);
      tick();
      chk("a5_dv_one_cycle", dv, 0);
      wait_idle("a5", 200);

      // burst of 16 with one byte launched during the burst
      gap_on = 1; gap_from = cyc; base = n_dv; peak = 0;
      for (int i = 1; i <= 16; i++) begin
         wr = 1'b1; wbyte = 8'(i); tick();
      end
      wr = 1'b0;
      chk("burst_peak", peak, 15);
      wait_idle("burst", 2000);
      chk("burst_dv_count", n_dv - base, 16);
      gap_on = 0;

      // overflow: fill while a frame is in flight
      write_seq(1); tick();
      write_seq(16);
      chk("fill_full", full, 1);
      wr = 1'b1; wbyte = 8'hEE; tick(); wr = 1'b0;
      chk("ovf_count", cnt, 16);
      chk("ovf_flag", ovf, 1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("ovf_cleared", ovf, 0);
      wr = 1'b1; clr = 1'b1; wbyte = 8'hEE; tick(); wr = 1'b0; clr = 1'b0;
      chk("ovf_set_wins", ovf, 1);
      chk("ovf_count2", cnt, 16);
      clr = 1'b1; tick(); clr = 1'b0;
      wait_idle("ovf", 2000);

      // push and pop on the same edge at count 3
      write_seq(4);
      found = 0;
      for (int i = 0; i < 200; i++) begin
         if (m_sync && !m_pend && mq.size() > 0) begin found = 1; break; end
         tick();
      end
      chk("pp_found", found, 1);
      chk("pp_pre_count", cnt, 3);
      wr = 1'b1; wbyte = 8'($urandom); tick(); wr = 1'b0;
      chk("pp_count", cnt, 3);
      chk("pp_dv", dv, 1);
      wait_idle("pp", 1000);

      // reset in the middle of frame 2 of 4
      base = n_dv;
      write_seq(4);
      found = 0;
      for (int i = 0; i < 300; i++) begin
         if (n_dv - base >= 2) begin found = 1; break; end
         tick();
      end
      chk("frame2_found", found, 1);
      repeat (12) tick();
      chk("mid_frame_active", tx_act, 1);
      rst_n = 1'b0; model_reset();
      tick(); tick();
      chk("mid_rst_empty", empty, 1);
      rst_n = 1'b1;
      wr = 1'b1; wbyte = 8'h3C; tick(); wr = 1'b0;
      found = 0;
      for (int i = 0; i < 200; i++) begin
         if (!tx_act && !tx_done) begin found = 1; break; end
         chk("sync_hold_dv", dv, 0);
         chk("sync_hold_busy", busy, 1);
         tick();
      end
      chk("sync_release", found, 1);
      found = 0;
      for (int i = 0; i < 10; i++) begin
         if (dv) begin found = 1; break; end
         tick();
      end
      chk("post_rst_launch", found, 1);
      chk("post_rst_byte", txb, 8'h3C);
      wait_idle("post_rst", 500);

      // randomized traffic with occasional clears and resets
      for (int i = 0; i < 2500; i++) begin
         wr    = ($urandom_range(0, 99) < 35);
         wbyte = 8'($urandom);
         clr   = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 599) == 0) begin
            wr = 1'b0; clr = 1'b0;
            rst_n = 1'b0; model_reset();
            tick();
            rst_n = 1'b1;
         end
         tick();
      end
      wr = 1'b0; clr = 1'b0;
      wait_idle("final", 3000);
      repeat (5) tick();
      chk("rx_drained", rx_exp.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
